// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, default EAR hysteresis thresholds
// and the decimator sample-scaling function.
package audio_pkg;

   localparam int SAMPLE_W = 8;
   localparam int TOTAL_W_MAX = 13;
   localparam logic [SAMPLE_W-1:0] HYST_HI_DEF = 8'hA0;
   localparam logic [SAMPLE_W-1:0] HYST_LO_DEF = 8'h60;

   // A full window of ones scales to 256, which is one more than fits in 8 bits.
   function automatic logic [SAMPLE_W-1:0] scale_sample(
      input logic [TOTAL_W_MAX-1:0] total,
      input int                     shift
   );
      logic [TOTAL_W_MAX-1:0] scaled;
      scaled = total >> shift;
      if (scaled > 13'd255) begin
         return 8'hFF;
      end else begin
         return scaled[SAMPLE_W-1:0];
      end
   endfunction

endpackage

// File: rtl/ear_adc_if.sv
// Signal bundle between the EAR sigma-delta ADC and its pins / ULA consumer.
interface ear_adc_if import audio_pkg::*;;

   logic                cmp;
   logic                fb;
   logic [SAMPLE_W-1:0] sample;
   logic                strobe;
   logic                ear;

   modport master (output cmp, input fb, input sample, input strobe, input ear);
   modport slave  (input cmp, output fb, output sample, output strobe, output ear);

endinterface

// File: rtl/ear_adc_sync2.sv
// Generic two-flop synchroniser; only the first flop may go metastable.
module sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/ear_adc.sv
// First-order sigma-delta ADC for the EAR line: comparator feedback loop,
// box-car decimator to an 8-bit sample, and a hysteresis-cleaned ear bit.
module ear_adc import audio_pkg::*; #(
   parameter int                  WINDOW_LOG2 = 8,
   parameter logic [SAMPLE_W-1:0] HYST_HI     = HYST_HI_DEF,
   parameter logic [SAMPLE_W-1:0] HYST_LO     = HYST_LO_DEF
) (
   input  logic      clock,
   input  logic      reset,
   ear_adc_if.slave  bus
);

   localparam int W = WINDOW_LOG2;

   logic                s2;
   logic                fb_r;
   logic [W-1:0]        phase_r;
   logic [W:0]          acc_r;
   logic [SAMPLE_W-1:0] sample_r;
   logic                strobe_r;
   logic                ear_r;

   logic                wrap_s;
   logic [W:0]          total_s;
   logic [SAMPLE_W-1:0] scaled_s;
   logic                ear_next_s;

   sync2 u_sync (
      .clock (clock),
      .reset (reset),
      .d     (bus.cmp),
      .q     (s2)
   );

   assign wrap_s = (phase_r == {W{1'b1}});

   // Window total including the current fb bit, its scaled value, and the hysteresis decision.
   always_comb begin
      total_s    = acc_r + {{W{1'b0}}, fb_r};
      scaled_s   = scale_sample(13'(total_s), W - SAMPLE_W);
      ear_next_s = ear_r;
      if (scaled_s >= HYST_HI) begin
         ear_next_s = 1'b1;
      end else if (scaled_s <= HYST_LO) begin
         ear_next_s = 1'b0;
      end else begin
         ear_next_s = ear_r;
      end
   end

   // Feedback register, phase counter, accumulator and end-of-window sample update.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fb_r     <= 1'b0;
         phase_r  <= {W{1'b0}};
         acc_r    <= {(W+1){1'b0}};
         sample_r <= {SAMPLE_W{1'b0}};
         strobe_r <= 1'b0;
         ear_r    <= 1'b0;
      end else begin
         fb_r     <= s2;
         phase_r  <= phase_r + {{(W-1){1'b0}}, 1'b1};
         strobe_r <= wrap_s;
         if (wrap_s) begin
            acc_r    <= {(W+1){1'b0}};
            sample_r <= scaled_s;
            ear_r    <= ear_next_s;
         end else begin
            acc_r    <= total_s;
            sample_r <= sample_r;
            ear_r    <= ear_r;
         end
      end
   end

   assign bus.fb     = fb_r;
   assign bus.sample = sample_r;
   assign bus.strobe = strobe_r;
   assign bus.ear    = ear_r;

endmodule

// File: tb/tb_ear_adc.sv
// Directed bench for ear_adc: W=8 and W=10 instances share clock, reset and cmp stimulus.
module tb_ear_adc;

   logic clock = 1'b0;
   logic reset = 1'b0;

   ear_adc_if if8 ();
   ear_adc_if if10 ();

   ear_adc #(.WINDOW_LOG2(8)) dut8 (
      .clock (clock),
      .reset (reset),
      .bus   (if8.slave)
   );

   ear_adc #(.WINDOW_LOG2(10)) dut10 (
      .clock (clock),
      .reset (reset),
      .bus   (if10.slave)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int n = 0;          // edges since reset release
   int mode = 0;       // 0: cmp=0, 1: cmp=1, 2: toggle, 3: duty table
   bit ear_watch = 1'b0;
   logic prev_ear = 1'b0;
   int duty [5] = '{80, 144, 168, 144, 88};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Value driven after edge n is counted by the decimator at edge n+4.
   task automatic drive();
      int e;
      int w;
      int pos;
      logic v;
      e = n + 4;
      w = (e - 1) / 256;
      pos = (e - 1) % 256;
      case (mode)
         0: v = 1'b0;
         1: v = 1'b1;
         2: v = n[0];
         3: v = (w < 5) ? (pos >= 256 - duty[w]) : 1'b0;
         default: v = 1'b0;
      endcase
      if8.cmp = v;
      if10.cmp = v;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      n++;
      if (ear_watch) begin
         if (!if8.strobe) chk("ear_only_on_strobe", {31'd0, if8.ear}, {31'd0, prev_ear});
         prev_ear = if8.ear;
      end
      drive();
   endtask

   task automatic run_to(input int t);
      while (n < t) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      #2;
      reset = 1'b0;
      n = 0;
      drive();
   endtask

   initial begin
      if8.cmp = 1'b0;
      if10.cmp = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("rst_fb", {31'd0, if8.fb}, 32'd0);
      chk("rst_sample", {24'd0, if8.sample}, 32'd0);
      chk("rst_strobe", {31'd0, if8.strobe}, 32'd0);
      chk("rst_ear", {31'd0, if8.ear}, 32'd0);
      chk("rst_sample10", {24'd0, if10.sample}, 32'd0);

      // cmp held 0
      mode = 0;
      do_reset();
      run_to(256);
      chk("zero_strobe", {31'd0, if8.strobe}, 32'd1);
      chk("zero_sample1", {24'd0, if8.sample}, 32'h00);
      chk("zero_ear", {31'd0, if8.ear}, 32'd0);
      run_to(512);
      chk("zero_sample2", {24'd0, if8.sample}, 32'h00);
      chk("zero_fb", {31'd0, if8.fb}, 32'd0);

      // cmp held 1, then toggling
      mode = 1;
      do_reset();
      run_to(255);
      chk("one_nostrobe255", {31'd0, if8.strobe}, 32'd0);
      run_to(256);
      chk("one_strobe256", {31'd0, if8.strobe}, 32'd1);
      chk("one_sample_fill", {24'd0, if8.sample}, 32'hFD);
      chk("one_ear", {31'd0, if8.ear}, 32'd1);
      run_to(257);
      chk("one_strobe_width", {31'd0, if8.strobe}, 32'd0);
      run_to(512);
      chk("one_sample_sat", {24'd0, if8.sample}, 32'hFF);
      mode = 2;
      drive();
      run_to(1024);
      chk("tog_sample1", {24'd0, if8.sample}, 32'h80);
      chk("tog_ear_hold", {31'd0, if8.ear}, 32'd1);
      run_to(1280);
      chk("tog_sample2", {24'd0, if8.sample}, 32'h80);
      chk("tog_ear_hold2", {31'd0, if8.ear}, 32'd1);

      // reset mid-window
      mode = 1;
      do_reset();
      run_to(356);
      chk("mid_pre_sample", {24'd0, if8.sample}, 32'hFD);
      chk("mid_pre_fb", {31'd0, if8.fb}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_async_sample", {24'd0, if8.sample}, 32'h00);
      chk("mid_async_strobe", {31'd0, if8.strobe}, 32'd0);
      chk("mid_async_fb", {31'd0, if8.fb}, 32'd0);
      chk("mid_async_ear", {31'd0, if8.ear}, 32'd0);
      tick();
      #2 reset = 1'b0;
      n = 0;
      drive();
      run_to(255);
      chk("mid_nostrobe255", {31'd0, if8.strobe}, 32'd0);
      run_to(256);
      chk("mid_strobe256", {31'd0, if8.strobe}, 32'd1);
      chk("mid_sample", {24'd0, if8.sample}, 32'hFD);

      // hysteresis sweep
      mode = 3;
      do_reset();
      prev_ear = if8.ear;
      ear_watch = 1'b1;
      run_to(256);
      chk("hys_s0", {24'd0, if8.sample}, 32'h50);
      chk("hys_e0", {31'd0, if8.ear}, 32'd0);
      run_to(512);
      chk("hys_s1", {24'd0, if8.sample}, 32'h90);
      chk("hys_e1", {31'd0, if8.ear}, 32'd0);
      run_to(768);
      chk("hys_s2", {24'd0, if8.sample}, 32'hA8);
      chk("hys_e2", {31'd0, if8.ear}, 32'd1);
      run_to(1024);
      chk("hys_s3", {24'd0, if8.sample}, 32'h90);
      chk("hys_e3", {31'd0, if8.ear}, 32'd1);
      run_to(1280);
      chk("hys_s4", {24'd0, if8.sample}, 32'h58);
      chk("hys_e4", {31'd0, if8.ear}, 32'd0);
      ear_watch = 1'b0;

      // W=10: toggling, then held 1
      mode = 2;
      do_reset();
      run_to(1023);
      chk("w10_nostrobe1023", {31'd0, if10.strobe}, 32'd0);
      run_to(1024);
      chk("w10_strobe1024", {31'd0, if10.strobe}, 32'd1);
      chk("w10_sample_first", {24'd0, if10.sample}, 32'h7F);
      run_to(1025);
      chk("w10_strobe_width", {31'd0, if10.strobe}, 32'd0);
      run_to(2047);
      chk("w10_nostrobe2047", {31'd0, if10.strobe}, 32'd0);
      run_to(2048);
      chk("w10_strobe2048", {31'd0, if10.strobe}, 32'd1);
      chk("w10_sample_tog1", {24'd0, if10.sample}, 32'h80);
      run_to(3072);
      chk("w10_sample_tog2", {24'd0, if10.sample}, 32'h80);
      mode = 1;
      drive();
      run_to(5120);
      chk("w10_strobe5120", {31'd0, if10.strobe}, 32'd1);
      chk("w10_sample_sat", {24'd0, if10.sample}, 32'hFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
